reg_pipe: RTL and testbench
===========================

# reg_pipe

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data registers, each with a valid bit, joined by a valid/ready handshake with bubble collapsing. It is the next generation of the plain write-enabled register. Datapath blocks use it to retime long paths and absorb downstream stalls without losing or duplicating words. It also reports live occupancy and supports an optional synchronous flush.

## Interface
Parameters:
- WIDTH, 20, data width in bits (>= 1)
- DEPTH, 2, number of register stages (>= 1)
- RESET_VAL, 0, value loaded into every data register on reset

Ports:
- clk  input  1  clock, all state updates on rising edge
- arst_n_in  input  1  reset, synchronous active-low; sampled on rising edge of clk
- in_data  input  WIDTH  upstream data
- in_valid  input  1  upstream word present
- in_ready  output  1  pipeline accepts in_data this cycle
- out_data  output  WIDTH  data of last stage
- out_valid  output  1  last stage holds a word
- out_ready  input  1  downstream accepts out_data this cycle
- flush  input  1  synchronous flush request (see Configuration)
- count  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- Stage i (0 = input side, DEPTH-1 = output side) holds data_q[i] and v_q[i].
- Ready chain: rdy[DEPTH] = out_ready; rdy[i] = !v_q[i] | rdy[i+1]; in_ready = rdy[0]. Purely combinational from state and out_ready; in_ready never depends on in_valid.
- Stage i loads when rdy[i] is high:
  - data_q[i] <= upstream data (in_data for i = 0, else data_q[i-1]);
  - v_q[i] <= upstream valid (in_valid for i = 0, else v_q[i-1]).
- When rdy[i] is low, stage i holds both data and valid.
- A data register is written only when its upstream valid is high, which saves switching energy; the valid bit always updates when rdy[i] is high.
- Transfers:
  - in: in_valid & in_ready;
  - out: out_valid & out_ready.
- count register:
  - +1 on an in-transfer only;
  - -1 on an out-transfer only;
  - unchanged when both or neither occur.
  - Always equals the popcount of v_q; never exceeds DEPTH or underflows.
- out_data = data_q[DEPTH-1]; out_valid = v_q[DEPTH-1].
- Ordering is strictly FIFO: no word is dropped or duplicated under any out_ready pattern.
- Reset (arst_n_in low at a rising edge):
  - all v_q = 0, all data_q = RESET_VAL, count = 0.
  - Reset dominates flush and all transfers, including mid-stream.
  - Outputs after reset: out_valid 0, out_data RESET_VAL, in_ready 1, count 0.
- Simulation only (excluded under TARGET_SYNTHESIS): at time 0, add 17*(WIDTH+1)*DEPTH to tbench_top.area and print it.

## Timing
- Latency into an empty pipe: a word accepted at edge t is on out_data with out_valid high after edge t+DEPTH-1, i.e. DEPTH cycles after it was presented.
- Throughput: 1 word per cycle while out_ready is held high.
- Stall: with out_ready low, the pipe fills until count = DEPTH, then in_ready goes low in the same cycle.
  - Bubbles collapse: any empty stage accepts while downstream is stalled.
- Full pipe with out_ready high: in_ready is high in the same cycle, so pass-through continues with no bubble.
- DEPTH = 1: in_ready = !v_q[0] | out_ready.

## Configuration
- REG_PIPE_FLUSH_EN defined:
  - flush high at a rising edge clears all v_q and sets count to 0.
  - Data registers hold their values.
  - A simultaneous in-transfer is discarded; flush beats input.
  - in_ready remains combinational as specified; in_ready is not forced low during flush.
- REG_PIPE_FLUSH_EN undefined:
  - the flush port exists but is ignored, and no flush logic is synthesised.

## Structure
- Package reg_pipe_pkg holds:
  - function cnt_w(depth) returning $clog2(depth+1);
  - the AREA_PER_BIT constant (17).
- Sub-module reg_pipe_stage holds one data register and its valid bit, with inputs up_data, up_valid, load and flush.
  - reg_pipe instantiates DEPTH copies via a generate loop.
  - reg_pipe holds the ready chain and the count register.

## Test plan
- Reset and latency: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5; hold reset 2 cycles -> out_valid 0, out_data A5, count 0, in_ready 1. Send 8'h11 with out_ready=1 -> out_valid high after 3 edges with data 11.
- Full stall: DEPTH=3, out_ready=0, push 01,02,03,04 -> count reaches 3 and in_ready goes low while 04 is presented. Raise out_ready -> 01,02,03,04 emerge back to back.
- Streaming: out_ready=1, in_valid=1 with incrementing data for 100 cycles -> one word per cycle after initial latency, count constant at 3.
- Random backpressure: out_ready random 50%, in_valid random 70%, 1000 words -> output sequence equals input sequence and count always equals scoreboard occupancy.
- Flush (REG_PIPE_FLUSH_EN): DEPTH=3, count=2, flush=1 together with in_valid=1 -> next cycle count 0, out_valid 0; the flushed word never appears at the output.
- Reset mid-stream: count=3, drive arst_n_in low for 1 edge -> count 0, out_valid 0, out_data RESET_VAL, no stale word output afterwards.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared constants and helpers for the reg_pipe elastic pipeline.
//   cnt_w(depth)  - width of an occupancy counter able to hold 0..depth
//   AREA_PER_BIT  - simulation-only area weight per stored bit
package reg_pipe_pkg;

  localparam int unsigned AREA_PER_BIT = 17;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one elastic pipeline stage (data register + valid bit).
//   clk, arst_n_in : clock, synchronous active-low reset
//   up_data        : data from the upstream stage (or pipeline input)
//   up_valid       : valid from the upstream stage (or pipeline input)
//   load           : stage ready; take upstream valid (and data if valid)
//   flush          : clear the valid bit, data held
//   data_o/valid_o : stage contents
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int unsigned       WIDTH     = 20,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  input  logic             load,
  input  logic             flush,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= up_valid;
      // Bubbles are not written into the data register.
      if (up_valid) data_q <= up_data;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage elastic register pipeline with valid/ready handshake,
// bubble collapsing and live occupancy count.
//   clk, arst_n_in       : clock, synchronous active-low reset
//   in_data/in_valid     : upstream word;  in_ready  : word accepted this cycle
//   out_data/out_valid   : last stage;     out_ready : downstream accepts
//   flush                : synchronous flush (active only with REG_PIPE_FLUSH_EN)
//   count                : number of valid stages
// Macros: REG_PIPE_FLUSH_EN enables flush; TARGET_SYNTHESIS removes the
// simulation-only area report (REG_PIPE_TBENCH_AREA also accumulates it into
// tbench_top.area when that bench is present).
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 20,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      arst_n_in,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned     CW  = cnt_w(DEPTH);
  localparam logic [CW-1:0]   ONE = CW'(1);

  logic [WIDTH-1:0] data_s [DEPTH];
  logic [DEPTH-1:0] v_s;
  logic [DEPTH:0]   rdy;
  logic             flush_s;
  logic [CW-1:0]    count_q, count_d;
  logic             in_xfer, out_xfer;

`ifdef REG_PIPE_FLUSH_EN
  assign flush_s = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_s      = 1'b0;
`endif

  // A stage is ready when empty or when the stage after it is ready, so any
  // empty slot absorbs a word even while the output is stalled.
  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] up_data;
    logic             up_valid;

    if (i == 0) begin : g_first
      assign up_data  = in_data;
      assign up_valid = in_valid;
    end else begin : g_next
      assign up_data  = data_s[i-1];
      assign up_valid = v_s[i-1];
    end

    assign rdy[i] = !v_s[i] | rdy[i+1];

    reg_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .up_data   (up_data),
      .up_valid  (up_valid),
      .load      (rdy[i]),
      .flush     (flush_s),
      .data_o    (data_s[i]),
      .valid_o   (v_s[i])
    );
  end

  assign in_ready  = rdy[0];
  assign out_data  = data_s[DEPTH-1];
  assign out_valid = v_s[DEPTH-1];

  assign in_xfer  = in_valid & rdy[0];
  assign out_xfer = v_s[DEPTH-1] & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush_s)                    count_d = '0;
    else if (in_xfer && !out_xfer)  count_d = count_q + ONE;
    else if (!in_xfer && out_xfer)  count_d = count_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) count_q <= '0;
    else            count_q <= count_d;
  end

  assign count = count_q;

`ifndef TARGET_SYNTHESIS
  initial begin
`ifdef REG_PIPE_TBENCH_AREA
    tbench_top.area = tbench_top.area + AREA_PER_BIT * (WIDTH + 1) * DEPTH;
`endif
    $display("reg_pipe area: %0d", AREA_PER_BIT * (WIDTH + 1) * DEPTH);
  end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed + scoreboarded bench for reg_pipe (WIDTH 8, DEPTH 3).
module tb_reg_pipe;
  localparam int unsigned      W  = 8;
  localparam int unsigned      D  = 3;
  localparam logic [W-1:0]     RV = 8'hA5;

  logic         clk = 1'b0;
  logic         arst_n_in;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         flush;
  logic [1:0]   count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [W-1:0] sb [$];
  int unsigned  n_out;

  always #5 clk = ~clk;

  reg_pipe #(
    .WIDTH     (W),
    .DEPTH     (D),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle against the scoreboard; expected in_ready and count come from
  // the model occupancy, output words from the queue.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy);
    logic do_in;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, (sb.size() < D) || ordy);
    check("count", count, sb.size());
    do_in = iv & in_ready;
    if (out_valid && ordy) begin
      if (sb.size() == 0) check("stale_out", out_valid, 1'b0);
      else begin
        check("out_data", out_data, sb.pop_front());
        n_out++;
      end
    end
    if (do_in) sb.push_back(id);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int unsigned cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      step(1'b0, '0, 1'b1);
      cyc++;
    end
    check(tag, sb.size(), 0);
    check({tag, "_count"}, count, 0);
  endtask

  initial begin
    arst_n_in = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
    tick();
    tick();
    arst_n_in = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, RV);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1'b1);

    // Latency: word accepted at edge t visible after edge t+2.
    in_data = 8'h11; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_e0_valid", out_valid, 1'b0);
    tick();
    check("lat_e1_valid", out_valid, 1'b0);
    tick();
    check("lat_e2_valid", out_valid, 1'b1);
    check("lat_e2_data", out_data, 8'h11);
    check("lat_e2_count", count, 1);
    tick();
    check("lat_gone_valid", out_valid, 1'b0);
    check("lat_gone_count", count, 0);

    // Full stall then back-to-back release.
    out_ready = 1'b0;
    for (int unsigned k = 1; k <= 3; k++) begin
      in_data = W'(k); in_valid = 1'b1;
      #1;
      check("stall_in_ready", in_ready, 1'b1);
      tick();
    end
    in_data = 8'h04;
    #1;
    check("stall_full_count", count, 3);
    check("stall_full_in_ready", in_ready, 1'b0);
    check("stall_out_data", out_data, 8'h01);
    out_ready = 1'b1;
    #1;
    check("passthru_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int unsigned k = 2; k <= 4; k++) begin
      check("release_valid", out_valid, 1'b1);
      check("release_data", out_data, W'(k));
      tick();
    end
    check("release_empty", out_valid, 1'b0);
    check("release_count", count, 0);

    // Streaming at full rate.
    n_out = 0;
    for (int unsigned k = 0; k < 100; k++) step(1'b1, W'(k), 1'b1);
    check("stream_words_out", n_out, 97);
    check("stream_count", count, 3);
    drain("stream_drain");

    // Random backpressure.
    begin
      int unsigned n_in = 0;
      int unsigned cyc  = 0;
      n_out = 0;
      while (n_in < 1000 && cyc < 20000) begin
        logic iv, ordy;
        logic [W-1:0] d;
        iv   = ($urandom_range(99) < 70);
        ordy = ($urandom_range(99) < 50);
        d    = W'($urandom);
        if (iv && ((sb.size() < D) || ordy)) n_in++;
        step(iv, d, ordy);
        cyc++;
      end
      check("rand_accepted", n_in, 1000);
      drain("rand_drain");
      check("rand_words_out", n_out, 1000);
    end

`ifdef REG_PIPE_FLUSH_EN
    // Flush with count 2 and a simultaneous input word.
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    check("flush_pre_count", count, 2);
    in_valid = 1'b1; in_data = 8'h77; flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 1'b0);
    for (int unsigned k = 0; k < 5; k++) step(1'b0, '0, 1'b1);
    check("flush_after_count", count, 0);
`endif

    // Reset mid-stream with a full pipe and live handshakes.
    for (int unsigned k = 0; k < 3; k++) step(1'b1, W'(8'h50 + k), 1'b0);
    check("mid_pre_count", count, 3);
    arst_n_in = 1'b0; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    tick();
    arst_n_in = 1'b1; in_valid = 1'b0;
    sb.delete();
    #1;
    check("mid_count", count, 0);
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_out_data", out_data, RV);
    check("mid_in_ready", in_ready, 1'b1);
    for (int unsigned k = 0; k < 5; k++) step(1'b0, '0, 1'b1);
    step(1'b1, 8'h3C, 1'b1);
    drain("mid_resume");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
